// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// aes_pkg : AES S-box tables, byte type and legal parameter ranges.
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    localparam int LANES_MIN  = 1;
    localparam int LANES_MAX  = 16;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 3;

    localparam aes_byte_t AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t AES_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

`default_nettype wire

// File: rtl/aes_sbox_lut.sv
//------------------------------------------------------------------------------
// aes_sbox_lut : single-byte combinational S-box; inverse table only when
// INV_SBOX_EN is defined, otherwise i_inv is ignored.       Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module aes_sbox_lut
    import aes_pkg::*;
(
    input  aes_byte_t i_byte,
    input  logic      i_inv,
    output aes_byte_t o_byte
);

`ifdef INV_SBOX_EN
    assign o_byte = i_inv ? AES_INV_SBOX[i_byte] : AES_SBOX[i_byte];
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
    assign o_byte       = AES_SBOX[i_byte];
`endif

endmodule

`default_nettype wire

// File: rtl/sub_bytes_pipe.sv
//------------------------------------------------------------------------------
// sub_bytes_pipe : pipelined AES SubBytes engine with valid/ready on both
// sides; INV_SBOX_EN enables the per-beat inverse S-box.    Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy,
    output logic [15:0]          beat_cnt
);

    localparam int DW = 8 * LANES;

    if (LANES < LANES_MIN || LANES > LANES_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_param_check
        $error("sub_bytes_pipe: LANES or STAGES out of range");
    end

    logic [DW-1:0] w_sub;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_lut u_lut (
            .i_byte (in_data[8*l +: 8]),
            .i_inv  (in_inv),
            .o_byte (w_sub[8*l +: 8])
        );
    end

    logic [STAGES-1:0]            r_valid;
    logic [STAGES-1:0][DW-1:0]    r_data;
    logic [STAGES-1:0][TAG_W-1:0] r_tag;
    logic [15:0]                  r_beat_cnt;
    logic [STAGES:0]              w_take;

    // w_take[k]: stage k may load this cycle; walks back from the output so
    // bubbles collapse and in_ready never depends on in_valid.
    always_comb begin
        w_take         = '0;
        w_take[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_take[k] = ~r_valid[k] | w_take[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
            r_tag   <= '0;
        end else begin
            if (w_take[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_sub;
                    r_tag[0]  <= in_tag;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_take[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                        r_tag[k]  <= r_tag[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (out_valid && out_ready) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign in_ready  = w_take[0];
    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign busy      = |r_valid;
    assign beat_cnt  = r_beat_cnt;

endmodule

`default_nettype wire

// File: doc/sub_bytes_pipe.md
Name: sub_bytes_pipe

Overview:
- Parametrised, pipelined AES SubBytes engine. Substitutes LANES bytes per beat through the forward or inverse S-box.
- Uses a valid/ready handshake on both sides.
- Serves the key-expansion path (LANES=4, one word for SubWord) and the round datapath (LANES=16, full state).

Parameters:
- LANES, 4, number of bytes substituted per beat; legal 1..16.
- STAGES, 2, pipeline register depth = latency in cycles; legal 1..3.
- TAG_W, 4, width of the opaque sideband tag carried alongside each beat; legal 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept a beat this cycle
- in_data  in  8*LANES  input bytes; lane i = bits [8i+7:8i]
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; per beat
- in_tag  in  TAG_W  sideband tag, returned unchanged with the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_data  out  8*LANES  substituted bytes, same lane order as in_data
- out_tag  out  TAG_W  tag of the beat on out_data
- busy  out  1  any pipeline stage holds a valid beat
- beat_cnt  out  16  count of completed output handshakes; wraps FFFF->0000

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: asserting rst_n=0 clears, at any time, all stage valid bits, all stage data/tag/mode registers and beat_cnt to 0. Outputs during and immediately after reset:
  - out_valid=0, out_data=0, out_tag=0, busy=0, beat_cnt=0.
  - in_ready=1 once rst_n is high.
- Reset mid-operation: in-flight beats are discarded, with no partial output.
- Pipeline: STAGES register stages S1..SN.
  - The S-box lookup is combinational between the input and S1.
  - Later stages only carry data, tag and valid.
- Stage advance rule: stage k loads from stage k-1 when stage k is empty or stage k+1 (or the output, for k=N) accepts this cycle. Bubbles therefore collapse.
- in_ready = (S1 empty) or (S1 advances this cycle). in_ready is combinational from out_ready through the stage-valid chain, with no combinational path from in_valid.
- Transfer rules:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - Throughput is 1 beat/cycle when out_ready is held high.
  - Latency is exactly STAGES cycles from input transfer to out_valid with no backpressure.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_tag are held stable. No beat is dropped or duplicated.
- Simultaneous events: input and output transfers in the same cycle on a full pipeline are legal. The pipeline stays full and in_ready stays 1.
- Mode is per beat: in_inv is sampled with its beat, so forward and inverse beats may interleave back-to-back.
- busy = OR of all stage valid bits.
- beat_cnt increments by 1 on each output transfer and wraps modulo 2^16.

Optional Feature:
- INV_SBOX_EN defined:
  - Inverse table is instantiated.
  - in_inv=1 selects the inverse S-box per lane.
- INV_SBOX_EN undefined:
  - No inverse table logic.
  - in_inv is ignored; every beat uses the forward S-box.
  - Port list is unchanged.

Decomposition:
- Package aes_pkg holds:
  - the 256-entry forward S-box constant table AES_SBOX;
  - the inverse table AES_INV_SBOX;
  - the byte typedef aes_byte_t;
  - LANES/STAGES legal-range constants.
- Sub-module aes_sbox_lut: one byte in, inv select, one byte out, purely combinational. It is instantiated LANES times via generate.
- Pipeline control (valid chain, advance enables) stays in sub_bytes_pipe.

Test Plan:
- Forward, latency and tag (LANES=4, STAGES=2): in_data=32'h00_01_52_ff, in_inv=0, tag=4'h5, out_ready=1 -> exactly 2 cycles later out_data=32'h63_7c_00_16, out_tag=4'h5, beat_cnt=1.
- Inverse and interleave (INV_SBOX_EN): send 32'h63_7c_00_16 with inv=1, immediately followed by 32'h53_00_00_00 with inv=0 -> required outputs, on consecutive cycles:
  - 32'h00_01_52_ff
  - 32'hed_63_63_63
- Backpressure: hold out_ready=0, offer 3 consecutive beats -> 2 accepted, then in_ready=0. out_data is held stable on the first beat. On releasing out_ready, all 3 beats emerge in order with no loss or duplication, and beat_cnt=3.
- Full throughput and wrap: 70000 back-to-back random beats with out_ready=1 -> every output matches the table model, one output per cycle after fill, and final beat_cnt = 70000 mod 65536 = 4464.
- Reset mid-operation: pipeline full, then rst_n pulsed low for 1 cycle asynchronously (not clock-aligned) -> out_valid, busy and beat_cnt read 0 immediately, and no stale beat appears after release.
- INV_SBOX_EN undefined: in_data=32'h63_63_63_63, in_inv=1 -> out_data=32'hfb_fb_fb_fb (forward result).
